// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared types and default timing for the VGA raster timing generator.
//   axis_timing_t  : per-axis timing (active, front porch, sync, back porch)
//   H_TIMING_640 / V_TIMING_480 : 640x480@60 default axis timings
//   clog2_min1()   : counter width helper that never returns a zero width
// ----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned syn;
        int unsigned bp;
    } axis_timing_t;

    // 640x480@60 defaults, kept as scalars so they can seed module parameters
    localparam int unsigned H640_ACTIVE = 32'd640;
    localparam int unsigned H640_FP     = 32'd16;
    localparam int unsigned H640_SYN    = 32'd96;
    localparam int unsigned H640_BP     = 32'd48;
    localparam int unsigned V480_ACTIVE = 32'd480;
    localparam int unsigned V480_FP     = 32'd10;
    localparam int unsigned V480_SYN    = 32'd2;
    localparam int unsigned V480_BP     = 32'd33;

    localparam axis_timing_t H_TIMING_640 = '{active: H640_ACTIVE, fp: H640_FP,
                                              syn: H640_SYN, bp: H640_BP};
    localparam axis_timing_t V_TIMING_480 = '{active: V480_ACTIVE, fp: V480_FP,
                                              syn: V480_SYN, bp: V480_BP};

    // Width needed to count 0..value-1, at least one bit so a degenerate
    // axis or divider still gets a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned value);
        if (value <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// ----------------------------------------------------------------------------
// vga_axis_timer
// One raster axis: a wrapping position counter plus region decode.
// Regions along the axis: sync [0,SYN) | back porch | active | front porch.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   step       : advance the counter by one position
//   clear      : force the counter to 0 (run enable low)
//   cnt        : current position
//   wrap       : step is taking the counter from its last position back to 0
//   in_sync    : position lies in the sync pulse
//   in_active  : position lies in the visible window
// ----------------------------------------------------------------------------
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter axis_timing_t TIMING = H_TIMING_640,
    parameter int unsigned  W      = 32'd10
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         clear,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_sync,
    output logic         in_active
);

    localparam int unsigned MAX = TIMING.active + TIMING.fp + TIMING.syn + TIMING.bp;

    localparam logic [W-1:0] LAST      = W'(MAX - 32'd1);
    localparam logic [W-1:0] SYN_END   = W'(TIMING.syn);
    localparam logic [W-1:0] ACT_START = W'(TIMING.syn + TIMING.bp);
    localparam logic [W-1:0] ACT_END   = W'(TIMING.syn + TIMING.bp + TIMING.active);

    generate
        if ((TIMING.active == 32'd0) || (TIMING.fp == 32'd0) ||
            (TIMING.syn == 32'd0) || (TIMING.bp == 32'd0)) begin : g_bad_timing
            $error("vga_axis_timer: every timing field must be non-zero");
        end
    endgenerate

    logic [W-1:0] cnt_r;

    assign cnt       = cnt_r;
    assign wrap      = step & (cnt_r == LAST);
    assign in_sync   = (cnt_r < SYN_END);
    assign in_active = (cnt_r >= ACT_START) && (cnt_r < ACT_END);

    // Position counter: clears on reset or disable, wraps after the last position
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clear) begin
            cnt_r <= {W{1'b0}};
        end else if (wrap) begin
            cnt_r <= {W{1'b0}};
        end else if (step) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator with a pixel-tick divider.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-low reset
//   en           : run enable; low parks the raster at the origin
//   h_sync       : horizontal sync, active level HPOL
//   v_sync       : vertical sync, active level VPOL
//   blank_n      : high only inside the visible window
//   posx, posy   : visible column / row, 0 outside the visible window
//   pix_tick     : 1-clk strobe on every output update
//   line_start   : 1-clk strobe on an update for column counter 0
//   frame_start  : 1-clk strobe on an update for column 0, line 0
// All outputs are registered from the counter state seen in the tick cycle,
// so they trail the counters by one clock and hold between ticks.
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned HACTIVE = H640_ACTIVE,
    parameter int unsigned HFP     = H640_FP,
    parameter int unsigned HSYN    = H640_SYN,
    parameter int unsigned HBP     = H640_BP,
    parameter int unsigned VACTIVE = V480_ACTIVE,
    parameter int unsigned VFP     = V480_FP,
    parameter int unsigned VSYN    = V480_SYN,
    parameter int unsigned VBP     = V480_BP,
    parameter bit          HPOL    = 1'b0,
    parameter bit          VPOL    = 1'b0,
    parameter int unsigned CLK_DIV = 32'd2,
    localparam int unsigned HMAX   = HSYN + HBP + HACTIVE + HFP,
    localparam int unsigned VMAX   = VSYN + VBP + VACTIVE + VFP,
    localparam int unsigned HW     = clog2_min1(HMAX),
    localparam int unsigned VW     = clog2_min1(VMAX),
    localparam int unsigned XW     = clog2_min1(HACTIVE),
    localparam int unsigned YW     = clog2_min1(VACTIVE)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          blank_n,
    output logic [XW-1:0] posx,
    output logic [YW-1:0] posy,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam axis_timing_t H_T = '{active: HACTIVE, fp: HFP, syn: HSYN, bp: HBP};
    localparam axis_timing_t V_T = '{active: VACTIVE, fp: VFP, syn: VSYN, bp: VBP};

    localparam int unsigned    DW       = clog2_min1(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 32'd1);
    localparam logic [HW-1:0]  HSS      = HW'(HSYN + HBP);
    localparam logic [VW-1:0]  VSS      = VW'(VSYN + VBP);

    generate
        if (CLK_DIV == 32'd0) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DW-1:0] dcnt_r;
    logic          tick_s;
    logic [HW-1:0] hcnt_s;
    logic [VW-1:0] vcnt_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          h_in_sync_s;
    logic          v_in_sync_s;
    logic          h_in_active_s;
    logic          v_in_active_s;
    logic          active_s;
    logic [XW-1:0] posx_s;
    logic [YW-1:0] posy_s;

    logic          h_sync_r;
    logic          v_sync_r;
    logic          blank_n_r;
    logic [XW-1:0] posx_r;
    logic [YW-1:0] posy_r;
    logic          pix_tick_r;
    logic          line_start_r;
    logic          frame_start_r;

    // Tick only while running; with CLK_DIV=1 dcnt_r stays 0 and every clk ticks
    assign tick_s = en & (dcnt_r == DIV_LAST);

    // Pixel-tick divider: counts 0..CLK_DIV-1, parked at 0 while disabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            dcnt_r <= {DW{1'b0}};
        end else if (!en) begin
            dcnt_r <= {DW{1'b0}};
        end else if (tick_s) begin
            dcnt_r <= {DW{1'b0}};
        end else begin
            dcnt_r <= dcnt_r + DW'(1);
        end
    end

    vga_axis_timer #(
        .TIMING (H_T),
        .W      (HW)
    ) u_h_timer (
        .clk       (clk),
        .rst       (rst),
        .step      (tick_s),
        .clear     (~en),
        .cnt       (hcnt_s),
        .wrap      (h_wrap_s),
        .in_sync   (h_in_sync_s),
        .in_active (h_in_active_s)
    );

    vga_axis_timer #(
        .TIMING (V_T),
        .W      (VW)
    ) u_v_timer (
        .clk       (clk),
        .rst       (rst),
        .step      (tick_s & h_wrap_s),
        .clear     (~en),
        .cnt       (vcnt_s),
        .wrap      (v_wrap_s),
        .in_sync   (v_in_sync_s),
        .in_active (v_in_active_s)
    );

    // v_wrap_s is not needed at this level; the V counter wraps itself
    logic unused_s;
    assign unused_s = v_wrap_s;

    // Offset into the visible window, computed at counter width then truncated
    assign active_s = h_in_active_s & v_in_active_s;
    assign posx_s   = XW'(hcnt_s - HSS);
    assign posy_s   = YW'(vcnt_s - VSS);

    // Output registers: load on tick, hold otherwise; strobes last one clk
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            h_sync_r      <= ~HPOL;
            v_sync_r      <= ~VPOL;
            blank_n_r     <= 1'b0;
            posx_r        <= {XW{1'b0}};
            posy_r        <= {YW{1'b0}};
            pix_tick_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (tick_s) begin
            h_sync_r      <= h_in_sync_s ? HPOL : ~HPOL;
            v_sync_r      <= v_in_sync_s ? VPOL : ~VPOL;
            blank_n_r     <= active_s;
            posx_r        <= active_s ? posx_s : {XW{1'b0}};
            posy_r        <= active_s ? posy_s : {YW{1'b0}};
            pix_tick_r    <= 1'b1;
            line_start_r  <= (hcnt_s == {HW{1'b0}});
            frame_start_r <= (hcnt_s == {HW{1'b0}}) && (vcnt_s == {VW{1'b0}});
        end else begin
            h_sync_r      <= h_sync_r;
            v_sync_r      <= v_sync_r;
            blank_n_r     <= blank_n_r;
            posx_r        <= posx_r;
            posy_r        <= posy_r;
            pix_tick_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign h_sync      = h_sync_r;
    assign v_sync      = v_sync_r;
    assign blank_n     = blank_n_r;
    assign posx        = posx_r;
    assign posy        = posy_r;
    assign pix_tick    = pix_tick_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Small raster: H 8/2/3/2 (15 ticks per line), V 4/1/2/1 (8 lines per frame),
// active-low syncs. dut runs with CLK_DIV=2, dut1 with CLK_DIV=1.
// Update n after enable reflects hcnt = n % 15, vcnt = (n / 15) % 8.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;

    logic       hs, vs, bl, pt, ls, fs;
    logic [2:0] posx;
    logic [1:0] posy;
    logic       hs1, vs1, bl1, pt1, ls1, fs1;
    logic [2:0] posx1;
    logic [1:0] posy1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         n;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [2:0] x;
        logic [1:0] y;
        logic       ls;
        logic       fs;
    } vec_t;

    vec_t tbl[19];

    // {pix_tick, h_sync, v_sync, blank_n, posx, posy, line_start, frame_start}
    localparam logic [10:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
        .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1),
        .HPOL(1'b0), .VPOL(1'b0), .CLK_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .h_sync(hs), .v_sync(vs), .blank_n(bl),
        .posx(posx), .posy(posy),
        .pix_tick(pt), .line_start(ls), .frame_start(fs)
    );

    vga_timing_gen #(
        .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
        .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1),
        .HPOL(1'b0), .VPOL(1'b0), .CLK_DIV(1)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .h_sync(hs1), .v_sync(vs1), .blank_n(bl1),
        .posx(posx1), .posy(posy1),
        .pix_tick(pt1), .line_start(ls1), .frame_start(fs1)
    );

    function automatic logic [10:0] outs0();
        return {pt, hs, vs, bl, posx, posy, ls, fs};
    endfunction

    function automatic logic [10:0] outs1();
        return {pt1, hs1, vs1, bl1, posx1, posy1, ls1, fs1};
    endfunction

    function automatic logic sel(input int which);
        case (which)
            0:       return pt;
            1:       return ls;
            2:       return fs;
            3:       return pt1;
            4:       return fs1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input int n, input bit h, input bit v, input bit b,
                                input int x, input int y, input bit l, input bit f);
        vec_t r;
        r.n  = n;
        r.hs = h;
        r.vs = v;
        r.bl = b;
        r.x  = 3'(x);
        r.y  = 2'(y);
        r.ls = l;
        r.fs = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the next pix_tick of dut; clks = negedges waited
    task automatic wait_update(output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
        end while (!pt && clks < 8);
    endtask

    // Clocks between two consecutive pulses of the selected strobe
    task automatic gap(input string name, input int which, input int bound, input int exp);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!sel(which) && c < bound);
        if (!sel(which)) begin
            check({name, "_first_pulse"}, 32'(c), 32'(exp));
        end else begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!sel(which) && c < bound);
            check(name, 32'(c), 32'(exp));
        end
    endtask

    initial begin
        int  c;
        int  cnt;
        int  upd;
        int  bad;
        bit  abort;

        tbl[0]  = mk(0,   0, 0, 0, 0, 0, 1, 1);
        tbl[1]  = mk(1,   0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(2,   0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(3,   1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(5,   1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(8,   1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(14,  1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(15,  0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(30,  0, 1, 0, 0, 0, 1, 0);
        tbl[9]  = mk(49,  1, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(50,  1, 1, 1, 0, 0, 0, 0);
        tbl[11] = mk(57,  1, 1, 1, 7, 0, 0, 0);
        tbl[12] = mk(58,  1, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(66,  1, 1, 1, 1, 1, 0, 0);
        tbl[14] = mk(99,  1, 1, 1, 4, 3, 0, 0);
        tbl[15] = mk(110, 1, 1, 0, 0, 0, 0, 0);
        tbl[16] = mk(119, 1, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(120, 0, 0, 0, 0, 0, 1, 1);
        tbl[18] = mk(188, 1, 1, 1, 3, 1, 0, 0);

        // Reset for 3 clks with the raster disabled
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outs0()), 32'(RESET_VEC));
        check("reset_outputs_div1", 32'(outs1()), 32'(RESET_VEC));

        // Enable: first update two clks later with both frame strobes
        rst = 1'b1;
        en  = 1'b1;
        wait_update(c);
        check("first_update_latency", 32'(c), 32'd2);
        check("first_update_strobes", {30'd0, ls, fs}, 32'd3);

        // h_sync low for 3 ticks = 6 clks, counted from this first update
        cnt = 0;
        while (hs == 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("hsync_low_clks", 32'(cnt), 32'd6);

        gap("pix_tick_period", 0, 10, 2);
        gap("line_start_period", 1, 40, 30);
        gap("frame_start_period", 2, 300, 240);

        // v_sync low for lines 0-1 = 30 ticks = 60 clks
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!fs && c < 300);
        cnt = 0;
        while (vs == 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("vsync_low_clks", 32'(cnt), 32'd60);

        // Park, then walk a fresh frame against the vector table
        en = 1'b0;
        @(negedge clk);
        check("disable_parks", 32'(outs0()), 32'(RESET_VEC));
        @(negedge clk);
        en    = 1'b1;
        upd   = -1;
        abort = 1'b0;
        for (int i = 0; i < 19 && !abort; i++) begin
            while (upd < tbl[i].n && !abort) begin
                wait_update(c);
                if (!pt) begin
                    check("update_timeout", 32'd0, 32'd1);
                    abort = 1'b1;
                end
                upd++;
            end
            if (!abort) begin
                check($sformatf("vec_n%0d", tbl[i].n), 32'(outs0()),
                      32'({1'b1, tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].x,
                           tbl[i].y, tbl[i].ls, tbl[i].fs}));
            end
        end

        // Counters now sit at hcnt=9, vcnt=4: drop en, outputs park next clk
        en = 1'b0;
        @(negedge clk);
        check("en_drop_mid_frame", 32'(outs0()), 32'(RESET_VEC));
        @(negedge clk);
        en = 1'b1;
        wait_update(c);
        check("reenable_latency", 32'(c), 32'd2);
        check("reenable_strobes", {30'd0, ls, fs}, 32'd3);

        // Reset mid-frame while enabled: reset wins, no strobes while held
        repeat (37) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_frame", 32'(outs0()), 32'(RESET_VEC));
        check("rst_mid_frame_div1", 32'(outs1()), 32'(RESET_VEC));
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (pt || ls || fs || pt1 || ls1 || fs1) bad++;
        end
        check("no_strobes_in_reset", 32'(bad), 32'd0);

        // CLK_DIV=1: tick every clk, frame period 120 clks
        rst = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!pt1 && c < 8);
        check("div1_first_latency", 32'(c), 32'd1);
        check("div1_first_frame_start", {31'd0, fs1}, 32'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!pt1) bad++;
        end
        check("div1_tick_every_clk", 32'(bad), 32'd0);
        gap("div1_frame_period", 4, 200, 120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
